// File: rtl/block_serial_add_sub_if.sv
// Operand/result bus for block_serial_add_sub.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; valid holds its payload until then.
interface block_serial_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             SUB;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OF;
    logic             busy;

    modport master (
        output start_valid, A, B, SUB, result_ready,
        input  start_ready, result_valid, S, Cout, OF, busy
    );

    modport slave (
        input  start_valid, A, B, SUB, result_ready,
        output start_ready, result_valid, S, Cout, OF, busy
    );
endinterface

// File: rtl/block_serial_add_sub.sv
// Multi-cycle add/sub: one BLOCK_SIZE slice per clock, LSB first, carry kept in a register.
// Optional zero flag output Z is enabled by defining BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN.
module block_serial_add_sub #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    block_serial_add_sub_if.slave         bus,
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
    output logic                          Z,
`endif
    output logic [1:0]                    dbg_state
);
    localparam int NUM_BLOCKS = WIDTH / BLOCK_SIZE;
    localparam int IDX_W      = $clog2(NUM_BLOCKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [WIDTH-1:0]      a_reg;
    logic [WIDTH-1:0]      b_reg;
    logic [WIDTH-1:0]      s_reg;
    logic                  carry;
    logic [IDX_W-1:0]      idx;
    logic                  cout_reg;
    logic                  of_reg;
    logic                  start_ready_reg;
    logic                  result_valid_reg;
    logic                  busy_reg;
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
    logic                  nz_reg;
    logic                  z_reg;
`endif

    // Operands shift right each RUN cycle, so the active block is always the low slice.
    logic [BLOCK_SIZE-1:0] blk_p;
    logic [BLOCK_SIZE-1:0] blk_g;
    logic [BLOCK_SIZE-1:0] blk_s;
    logic [BLOCK_SIZE:0]   blk_c;

    always_comb begin
        blk_p    = a_reg[BLOCK_SIZE-1:0] ^ b_reg[BLOCK_SIZE-1:0];
        blk_g    = a_reg[BLOCK_SIZE-1:0] & b_reg[BLOCK_SIZE-1:0];
        blk_c    = '0;
        blk_s    = '0;
        blk_c[0] = carry;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            blk_s[i]   = blk_p[i] ^ blk_c[i];
            blk_c[i+1] = blk_g[i] | (blk_p[i] & blk_c[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            a_reg            <= '0;
            b_reg            <= '0;
            s_reg            <= '0;
            carry            <= 1'b0;
            idx              <= '0;
            cout_reg         <= 1'b0;
            of_reg           <= 1'b0;
            start_ready_reg  <= 1'b1;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
            nz_reg           <= 1'b0;
            z_reg            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        // Subtraction is A + ~B + 1: invert B here and seed the carry with SUB.
                        a_reg           <= bus.A;
                        b_reg           <= bus.B ^ {WIDTH{bus.SUB}};
                        carry           <= bus.SUB;
                        idx             <= '0;
                        s_reg           <= '0;
                        start_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
                        nz_reg          <= 1'b0;
`endif
                        state           <= RUN;
                    end
                end
                RUN: begin
                    for (int b = 0; b < NUM_BLOCKS; b++) begin
                        if (idx == IDX_W'(b)) s_reg[b*BLOCK_SIZE +: BLOCK_SIZE] <= blk_s;
                    end
                    a_reg <= a_reg >> BLOCK_SIZE;
                    b_reg <= b_reg >> BLOCK_SIZE;
                    carry <= blk_c[BLOCK_SIZE];
                    idx   <= idx + 1'b1;
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
                    nz_reg <= nz_reg | (|blk_s);
`endif
                    if (idx == IDX_W'(NUM_BLOCKS - 1)) begin
                        cout_reg         <= blk_c[BLOCK_SIZE];
                        of_reg           <= blk_c[BLOCK_SIZE] ^ blk_c[BLOCK_SIZE-1];
                        result_valid_reg <= 1'b1;
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
                        z_reg            <= ~(nz_reg | (|blk_s));
`endif
                        state            <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        result_valid_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                        start_ready_reg  <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready  = start_ready_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.busy         = busy_reg;
    assign bus.S            = s_reg;
    assign bus.Cout         = cout_reg;
    assign bus.OF           = of_reg;
    assign dbg_state        = state;
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
    assign Z                = z_reg;
`endif
endmodule

// File: tb/tb_block_serial_add_sub.sv
// Directed and random operations on block_serial_add_sub, checked against an arithmetic reference.
module tb_block_serial_add_sub;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
  logic z;
`endif

  always #5 clk = ~clk;

  block_serial_add_sub_if #(.WIDTH(W)) bus ();

  block_serial_add_sub #(.WIDTH(W), .BLOCK_SIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
    .Z         (z),
`endif
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  // {z, of, cout, s}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] last_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int sa, sb, sr;
    logic [W:0] wide;
    logic [W-1:0] s;
    logic c, of;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      s  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      s    = wide[W-1:0];
      c    = wide[W];
      sr   = sa + sb;
    end
    of = (sr > 32767) || (sr < -32768);
    return {(s == '0), of, c, s};
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.SUB = sub;
    bus.start_valid = 1'b1;
    check("start_ready_idle", 32'(bus.start_ready), 32'd1);
    exp_q.push_back(model(a, b, sub));
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    // Scramble operands right after acceptance; they must not reach the result.
    bus.A = W'($urandom);
    bus.B = W'($urandom);
    bus.SUB = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      cnt++;
      #1;
      if (bus.result_valid) break;
    end
    check("latency", 32'(cnt), 32'd4);
  endtask

  task automatic check_result(input string tag);
    @(negedge clk);
    last_exp = exp_q.pop_front();
    check({tag, "_S"}, 32'(bus.S), 32'(last_exp[W-1:0]));
    check({tag, "_Cout"}, 32'(bus.Cout), 32'(last_exp[W]));
    check({tag, "_OF"}, 32'(bus.OF), 32'(last_exp[W+1]));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_start_ready"}, 32'(bus.start_ready), 32'd0);
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
    check({tag, "_Z"}, 32'(z), 32'(last_exp[W+2]));
`endif
  endtask

  task automatic finish_result();
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    @(negedge clk);
    check("idle_result_valid", 32'(bus.result_valid), 32'd0);
    check("idle_start_ready", 32'(bus.start_ready), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input string tag);
    start_op(a, b, sub);
    wait_result();
    check_result(tag);
    finish_result();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_S"}, 32'(bus.S), 32'd0);
    check({tag, "_Cout"}, 32'(bus.Cout), 32'd0);
    check({tag, "_OF"}, 32'(bus.OF), 32'd0);
    check({tag, "_start_ready"}, 32'(bus.start_ready), 32'd1);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
`ifdef BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN
    check({tag, "_Z"}, 32'(z), 32'd0);
`endif
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.result_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.SUB = 1'b0;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    run_op(16'h1234, 16'h4321, 1'b0, "add_basic");
    run_op(16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    run_op(16'h0000, 16'h0001, 1'b1, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b1, "sub_ovf");
    run_op(16'h00FF, 16'h0001, 1'b0, "add_cross_block");

    // Backpressure: DONE held, a start pulse in the window is ignored
    start_op(16'h0F0F, 16'h7070, 1'b1);
    wait_result();
    check_result("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start_valid = (i == 2);
      bus.A = 16'hAAAA;
      bus.B = 16'h5555;
      check("bp_hold_S", 32'(bus.S), 32'(last_exp[W-1:0]));
      check("bp_hold_Cout", 32'(bus.Cout), 32'(last_exp[W]));
      check("bp_hold_OF", 32'(bus.OF), 32'(last_exp[W+1]));
      check("bp_hold_valid", 32'(bus.result_valid), 32'd1);
      check("bp_hold_start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    finish_result();
    run_op(16'h0102, 16'h0304, 1'b0, "after_bp");

    // Asynchronous reset mid-operation
    start_op(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0003, 16'h0004, 1'b0, "post_reset");

    // Random operations
    for (int n = 0; n < 24; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");
    end
    run_op(16'h5A5A, 16'h5A5A, 1'b1, "sub_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/block_serial_add_sub.md
Name: block_serial_add_sub

Overview:
- Multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair one BLOCK_SIZE-bit block per clock, LSB block first.
- The block-to-block carry (borrow for subtraction) is held in a register instead of being resolved by lookahead logic.
- Used where area matters more than latency: the sequential counterpart of the combinational lookahead adder path.
- Valid/ready on both input and output sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of BLOCK_SIZE.
- BLOCK_SIZE, 4, bits processed per RUN cycle; NUM_BLOCKS = WIDTH/BLOCK_SIZE (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands and SUB valid
- start_ready  output  1  block can accept an operation (high only in IDLE)
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- SUB  input  1  0 = A+B, 1 = A-B
- result_valid  output  1  S/Cout/OF valid (high only in DONE)
- result_ready  input  1  consumer accepts the result
- S  output  WIDTH  sum/difference
- Cout  output  1  carry out of MSB; for SUB, 1 = no borrow (A >= B unsigned)
- OF  output  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock/reset: one clock domain; reset asynchronous, active-low.
- Reset values: state = IDLE; S, Cout, OF, result_valid, busy = 0; start_ready = 1; internal carry and block index = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid at an edge: register A; register B XOR {WIDTH{SUB}}; carry register <= SUB; index <= 0; clear S; go to RUN.
- RUN:
  - Each cycle: block[idx] = A_blk + B_blk + carry (P/G formed internally, ripple or lookahead within the block).
  - Write the result into S[idx*BLOCK_SIZE +: BLOCK_SIZE]; carry <= block carry out; idx <= idx+1.
  - On the last block (idx = NUM_BLOCKS-1): Cout <= block carry out; OF <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; go to DONE.
- DONE:
  - result_valid = 1; S, Cout and OF held stable.
  - On result_ready, go to IDLE; result_valid drops the next cycle. Cout and OF hold their values until the next acceptance.
- Latency: acceptance at edge k gives result_valid high from edge k+NUM_BLOCKS (4 cycles by default).
- Throughput: at best one operation per NUM_BLOCKS+2 cycles. There is no IDLE bypass; start_ready stays 0 from acceptance until DONE exits.
- Inputs ignored outside IDLE:
  - start_valid in RUN/DONE has no effect.
  - A/B/SUB changes after acceptance do not affect the result.
- Backpressure: result_ready low holds DONE indefinitely with outputs frozen.
- Reset mid-operation: an asynchronous return to the reset values. The in-flight operation is discarded; no partial result is presented.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - OF is the two's-complement overflow for both ADD and SUB.
  - Cout for SUB is the inverted borrow.

Optional Feature:
- Macro: BLOCK_SERIAL_ADD_SUB_ZERO_FLAG_EN.
- Defined: adds output port Z (1 bit).
  - Z is updated together with Cout/OF on the last RUN cycle; Z = 1 iff the final S == 0.
  - Reset value 0; held through DONE until the next acceptance.
  - Z is computed from a sticky per-block "nonzero" register, not from a WIDTH-wide compare.
- Undefined: port Z and its logic are absent; all other behaviour is identical.

Test Plan:
1. A=16'h1234, B=16'h4321, SUB=0 -> S=16'h5555, Cout=0, OF=0; result_valid high exactly 4 edges after acceptance.
2. A=16'h7FFF, B=16'h0001, SUB=0 -> S=16'h8000, Cout=0, OF=1. Then A=16'hFFFF, B=16'h0001, SUB=0 -> S=16'h0000, Cout=1, OF=0 (Z=1 with macro).
3. SUB=1, A=16'h0000, B=16'h0001 -> S=16'hFFFF, Cout=0, OF=0. Then SUB=1, A=16'h8000, B=16'h0001 -> S=16'h7FFF, Cout=1, OF=1.
4. result_ready held low for 5 cycles in DONE:
   - S/Cout/OF stable; start_ready=0.
   - A start_valid pulse with new operands in that window is ignored.
   - After result_ready=1: IDLE, start_ready=1.
5. rst_n pulsed low after 2 RUN cycles:
   - Immediately (asynchronously): result_valid=0, busy=0, S=0, Cout=0, OF=0, start_ready=1.
   - Next operation (16'h0003+16'h0004) -> S=16'h0007.
6. Change A/B/SUB on the cycle after acceptance of 16'h00FF+16'h0001 -> S=16'h0100, unaffected by the changed inputs.
